// File: rtl/uart_tx_cfg_if.sv
// uart_tx_cfg_if: producer-to-transmitter word handshake.
// A word moves on any edge where pi_valid && pi_ready.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] pi_data;
  logic                 pi_valid;
  logic                 pi_ready;

  modport master (
    output pi_data,
    output pi_valid,
    input  pi_ready
  );

  modport slave (
    input  pi_data,
    input  pi_valid,
    output pi_ready
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with input FIFO, 5..9 data bits,
// optional odd/even parity and one or two stop bits.
module uart_tx_cfg #(
  parameter int CLK_FRE    = 50_000_000,
  parameter int BPS        = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             sys_clk,
  input  logic                             sys_rst_n,
  uart_tx_cfg_if.slave                     pi,
  output logic                             tx,
  output logic                             tx_busy,
  output logic                             tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_cnt
);

  localparam int BIT_CLKS = CLK_FRE / BPS;
  localparam int BW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam int IW = $clog2(DATA_BITS);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [BW-1:0] BAUD_LAST = BW'(BIT_CLKS - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q;
  logic [AW-1:0]        rd_ptr_d;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;
  logic                 avail_q;
  logic                 push;
  logic                 pop;
  logic                 can_pop;
  logic [DATA_BITS-1:0] head;

  state_t               state_q;
  state_t               state_d;
  logic [BW-1:0]        baud_q;
  logic [BW-1:0]        baud_d;
  logic [IW-1:0]        bit_q;
  logic [IW-1:0]        bit_d;
  logic                 stop_q;
  logic                 stop_d;
  logic [DATA_BITS-1:0] shreg_q;
  logic [DATA_BITS-1:0] shreg_d;
  logic                 par_q;
  logic                 par_d;
  logic                 tx_q;
  logic                 tx_d;
  logic                 done_q;
  logic                 done_d;
  logic                 baud_last;

  assign pi.pi_ready = (cnt_q != FULL);
  assign push        = pi.pi_valid && pi.pi_ready;
  assign head        = mem_q[rd_ptr_q];
  // a fresh word waits one cycle before it can be popped
  assign can_pop     = avail_q && (cnt_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= pi.pi_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      avail_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      avail_q  <= (cnt_q != '0);
    end
  end

  assign baud_last = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_last ? '0 : baud_q + BW'(1);
    bit_d   = bit_q;
    stop_d  = stop_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (can_pop) begin
          pop     = 1'b1;
          shreg_d = head;
          par_d   = (PARITY == 1) ? ~^head : ^head;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_last) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shreg_q[0];
        end
      end
      DATA: begin
        if (baud_last) begin
          if (bit_q == BIT_LAST) begin
            stop_d = 1'b0;
            if (PARITY != 0) begin
              state_d = PAR;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + IW'(1);
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end
      end
      PAR: begin
        if (baud_last) begin
          state_d = STOP;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (baud_last) begin
          if (stop_q == STOP_LAST) begin
            done_d = 1'b1;
            // back-to-back: next start bit follows the stop bit directly
            if (can_pop) begin
              pop     = 1'b1;
              shreg_d = head;
              par_d   = (PARITY == 1) ? ~^head : ^head;
              state_d = START;
              tx_d    = 1'b0;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign tx       = tx_q;
  assign tx_busy  = (state_q != IDLE);
  assign tx_done  = done_q;
  assign fifo_cnt = cnt_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed frame checks on four transmitter
// configurations (8N1, 8E1, 8O1, 7N2), BIT_CLKS = 10.
module tb_uart_tx_cfg;

  logic clk;
  logic rst_n;
  logic [3:0] vv;
  logic [7:0] d0, d1, d2;
  logic [6:0] d3;
  logic [3:0] txv, busyv, donev, rdyv;
  logic [3:0][2:0] cntv;

  int total = 0;
  int bad = 0;

  typedef struct {
    int         u;
    logic [7:0] d;
    logic [11:0] bits;
    int         nb;
  } vec_t;

  vec_t vt [10];
  logic [7:0] w [6];

  uart_tx_cfg_if #(.DATA_BITS(8)) if0 ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if1 ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if2 ();
  uart_tx_cfg_if #(.DATA_BITS(7)) if3 ();

  assign if0.pi_valid = vv[0];
  assign if1.pi_valid = vv[1];
  assign if2.pi_valid = vv[2];
  assign if3.pi_valid = vv[3];
  assign if0.pi_data  = d0;
  assign if1.pi_data  = d1;
  assign if2.pi_data  = d2;
  assign if3.pi_data  = d3;
  assign rdyv[0] = if0.pi_ready;
  assign rdyv[1] = if1.pi_ready;
  assign rdyv[2] = if2.pi_ready;
  assign rdyv[3] = if3.pi_ready;

  uart_tx_cfg #(
    .CLK_FRE(1_000_000), .BPS(100_000), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u0 (
    .sys_clk(clk), .sys_rst_n(rst_n), .pi(if0),
    .tx(txv[0]), .tx_busy(busyv[0]), .tx_done(donev[0]),
    .fifo_cnt(cntv[0])
  );

  uart_tx_cfg #(
    .CLK_FRE(1_000_000), .BPS(100_000), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .pi(if1),
    .tx(txv[1]), .tx_busy(busyv[1]), .tx_done(donev[1]),
    .fifo_cnt(cntv[1])
  );

  uart_tx_cfg #(
    .CLK_FRE(1_000_000), .BPS(100_000), .DATA_BITS(8),
    .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u2 (
    .sys_clk(clk), .sys_rst_n(rst_n), .pi(if2),
    .tx(txv[2]), .tx_busy(busyv[2]), .tx_done(donev[2]),
    .fifo_cnt(cntv[2])
  );

  uart_tx_cfg #(
    .CLK_FRE(1_000_000), .BPS(100_000), .DATA_BITS(7),
    .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) u3 (
    .sys_clk(clk), .sys_rst_n(rst_n), .pi(if3),
    .tx(txv[3]), .tx_busy(busyv[3]), .tx_done(donev[3]),
    .fifo_cnt(cntv[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input int u, input logic v, input logic [7:0] d);
    vv[u] = v;
    case (u)
      0: d0 = d;
      1: d1 = d;
      2: d2 = d;
      default: d3 = d[6:0];
    endcase
  endtask

  task automatic send(input int u, input logic [7:0] d);
    @(negedge clk);
    set_in(u, 1'b1, d);
    chk($sformatf("ready u%0d", u), 16'(rdyv[u]), 16'd1);
    @(posedge clk);
    @(negedge clk);
    set_in(u, 1'b0, d);
  endtask

  task automatic wait_start(input int u);
    int k;
    for (k = 0; k < 60; k++) begin
      if (txv[u] == 1'b0) break;
      @(negedge clk);
    end
    if (k == 60) chk($sformatf("start timeout u%0d", u), 16'(txv[u]), 16'd0);
  endtask

  // first sample is the cycle right after the start-bit edge
  task automatic check_frame(input int u, input logic [11:0] bits,
                             input int nb, input bit last);
    bit ok;
    logic act;
    for (int b = 0; b < nb; b++) begin
      ok = 1'b1;
      act = txv[u];
      for (int j = 0; j < 10; j++) begin
        if (txv[u] !== bits[b]) begin
          ok = 1'b0;
          act = txv[u];
        end
        if (busyv[u] !== 1'b1) ok = 1'b0;
        if (!(b == 0 && j == 0) && donev[u] !== 1'b0) ok = 1'b0;
        @(negedge clk);
      end
      if (!ok) $display("  u%0d bit %0d line=%b", u, b, act);
      chk($sformatf("u%0d frame bit %0d", u, b), 16'(ok), 16'd1);
    end
    chk($sformatf("u%0d tx_done end", u), 16'(donev[u]), 16'd1);
    chk($sformatf("u%0d tx_busy end", u), 16'(busyv[u]), 16'(!last));
    if (last) begin
      @(negedge clk);
      chk($sformatf("u%0d tx_done 1cyc", u), 16'(donev[u]), 16'd0);
      chk($sformatf("u%0d tx idle", u), 16'(txv[u]), 16'd1);
    end
  endtask

  task automatic send_and_check(input int u, input logic [7:0] d,
                                input logic [11:0] bits, input int nb);
    send(u, d);
    @(negedge clk);
    chk($sformatf("u%0d latency edge1", u), 16'(txv[u]), 16'd1);
    @(negedge clk);
    chk($sformatf("u%0d latency edge2", u), 16'(txv[u]), 16'd0);
    wait_start(u);
    check_frame(u, bits, nb, 1'b1);
  endtask

  initial begin
    vt[0] = '{0, 8'h55, 12'h2AA, 10};
    vt[1] = '{1, 8'h07, 12'h60E, 11};
    vt[2] = '{2, 8'h07, 12'h40E, 11};
    vt[3] = '{3, 8'h41, 12'h382, 10};
    vt[4] = '{0, 8'h00, 12'h200, 10};
    vt[5] = '{0, 8'hFF, 12'h3FE, 10};
    vt[6] = '{1, 8'h80, 12'h700, 11};
    vt[7] = '{2, 8'h00, 12'h600, 11};
    vt[8] = '{3, 8'h7F, 12'h3FE, 10};
    vt[9] = '{0, 8'hA5, 12'h34A, 10};
    w[0] = 8'h3C; w[1] = 8'hC3; w[2] = 8'h01;
    w[3] = 8'h80; w[4] = 8'h5A; w[5] = 8'hE7;

    vv = '0;
    d0 = 8'h00; d1 = 8'h00; d2 = 8'h00; d3 = 7'h00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 4; u++) begin
      chk($sformatf("rst tx u%0d", u), 16'(txv[u]), 16'd1);
      chk($sformatf("rst busy u%0d", u), 16'(busyv[u]), 16'd0);
      chk($sformatf("rst done u%0d", u), 16'(donev[u]), 16'd0);
      chk($sformatf("rst ready u%0d", u), 16'(rdyv[u]), 16'd1);
      chk($sformatf("rst cnt u%0d", u), 16'(cntv[u]), 16'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      send_and_check(vt[i].u, vt[i].d, vt[i].bits, vt[i].nb);
    end

    // six words held on the handshake against a 4-deep FIFO
    fork
      begin : prod
        int n;
        bit r;
        bit fchk;
        n = 0;
        fchk = 1'b0;
        @(negedge clk);
        set_in(0, 1'b1, w[0]);
        for (int k = 0; k < 400 && n < 6; k++) begin
          r = rdyv[0];
          if (n == 5 && r) chk("ready rise with done", 16'(donev[0]), 16'd1);
          @(posedge clk);
          if (r) n++;
          @(negedge clk);
          set_in(0, n < 6, w[(n < 6) ? n : 5]);
          if (n == 5 && !fchk) begin
            fchk = 1'b1;
            chk("full ready", 16'(rdyv[0]), 16'd0);
            chk("full cnt", 16'(cntv[0]), 16'd4);
          end
        end
        chk("accepted words", 16'(n), 16'd6);
      end
      begin : cons
        @(negedge clk);
        wait_start(0);
        for (int k = 0; k < 6; k++) begin
          check_frame(0, {3'b000, 1'b1, w[k], 1'b0}, 10, k == 5);
        end
      end
    join
    chk("fifo drained", 16'(cntv[0]), 16'd0);

    // data changed after acceptance must not reach the line
    send(0, 8'hA3);
    set_in(0, 1'b0, 8'hFF);
    @(negedge clk);
    @(negedge clk);
    wait_start(0);
    check_frame(0, 12'h346, 10, 1'b1);

    // reset 35 clocks into a frame with two words still queued
    send(0, 8'h11);
    send(0, 8'h22);
    send(0, 8'h33);
    chk("pre-rst line", 16'(txv[0]), 16'd0);
    repeat (33) @(negedge clk);
    chk("pre-rst cnt", 16'(cntv[0]), 16'd2);
    chk("pre-rst busy", 16'(busyv[0]), 16'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid rst tx", 16'(txv[0]), 16'd1);
    chk("mid rst cnt", 16'(cntv[0]), 16'd0);
    chk("mid rst ready", 16'(rdyv[0]), 16'd1);
    chk("mid rst busy", 16'(busyv[0]), 16'd0);
    chk("mid rst done", 16'(donev[0]), 16'd0);
    begin
      bit quiet;
      quiet = 1'b1;
      for (int k = 0; k < 150; k++) begin
        @(negedge clk);
        if (donev[0] !== 1'b0 || txv[0] !== 1'b1) quiet = 1'b0;
      end
      chk("post rst quiet", 16'(quiet), 16'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
